// File: rtl/riscv_mem_arbiter.sv
// Purpose: shares one synchronous-read word memory between instruction fetch and load/store data.
// Latency: grant and mem_en one cycle after the request is sampled; read data returns MEM_LAT+1 cycles after grant.
// Backpressure: one access in flight; requests are held by the requester until its grant pulse, and none are granted while a read is pending.
module riscv_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction-fetch requester
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // load/store requester
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    // memory port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int SW    = $clog2(STARVE_LIM + 1);

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_READ_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  lat_q, lat_d;
    logic              owner_q, owner_d;      // 1 = data requester owns the pending read
    logic [SW-1:0]     starve_q, starve_d;

    logic              if_gnt_q, if_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic read_done;
    logic arb_ok;
    logic fetch_win;
    logic data_win;

    // The completing edge of a read also arbitrates, so the next access can start
    // in the same cycle the read data is returned.
    assign read_done = (state_q == ST_READ_WAIT) && (lat_q == '0);
    assign arb_ok    = (state_q == ST_IDLE) || read_done;

    // Data normally wins; fetch wins once it has watched STARVE_LIM data grants go by.
    assign fetch_win = arb_ok && if_req && (!d_req || (starve_q == SW'(STARVE_LIM)));
    assign data_win  = arb_ok && d_req && !fetch_win;

    // Next-state and registered-output computation for the arbiter FSM.
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                // arbitration below handles everything in IDLE
            end
            ST_READ_WAIT: begin
                if (lat_q != '0) begin
                    lat_d = lat_q - 1'b1;
                end else begin
                    // Return the word only to the owner; the other rdata register is untouched.
                    state_d = ST_IDLE;
                    if (owner_q) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = mem_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Starvation count only runs while fetch is actually waiting.
        if (!if_req || fetch_win) begin
            starve_d = '0;
        end else if (data_win && (starve_q != SW'(STARVE_LIM))) begin
            starve_d = starve_q + 1'b1;
        end

        if (fetch_win) begin
            if_gnt_d   = 1'b1;
            mem_en_d   = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
            state_d    = ST_READ_WAIT;
            lat_d      = CNT_W'(MEM_LAT);
            owner_d    = 1'b0;
        end

        if (data_win) begin
            d_gnt_d     = 1'b1;
            mem_en_d    = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            // Stores finish in the grant cycle, so only loads wait for data.
            if (!d_we) begin
                state_d = ST_READ_WAIT;
                lat_d   = CNT_W'(MEM_LAT);
                owner_d = 1'b1;
            end
        end
    end

    // State and output registers; reset drops any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            owner_q     <= 1'b0;
            starve_q    <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Two-port arbiter sharing the CPU's single 1024×32 word memory between the instruction-fetch requester and the load/store data requester of the multi-cycle RISC-V core. It serialises requests with a single outstanding access and fixed data-over-fetch priority, with a starvation guard for fetch. It drives a synchronous-read memory with a parameterised read latency and returns read data through registered valid pulses. It sits between the core's fetch/LSU logic and the memory array.

## Interface
- ADDR_W, 10, word-address width (1024 words)
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles (≥1)
- STARVE_LIM, 4, consecutive data grants allowed while fetch waits (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  one-cycle grant pulse to fetch
- if_rvalid  out  1  one-cycle fetch read-data valid
- if_rdata  out  DATA_W  fetch read data, held until next fetch return
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle grant pulse to data
- d_rvalid  out  1  one-cycle load-data valid (loads only)
- d_rdata  out  DATA_W  load data, held until next load return
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable (qualified by mem_en)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

## Operation
- States: IDLE, READ_WAIT. All outputs except none are registered.
- IDLE, edge sampling requests: winner chosen; mem_en, mem_we, mem_addr, mem_wdata and winner's gnt registered high for exactly one cycle (cycle T).
- Priority: d_req wins over if_req, unless starve_cnt == STARVE_LIM and if_req high, then fetch wins.
- starve_cnt: increments on each data grant while if_req high; clears on fetch grant or any edge with if_req low; saturates at STARVE_LIM.
- Store grant: stays IDLE; next grant possible in T+1 (back-to-back stores at one per cycle).
- Load/fetch grant: enter READ_WAIT with latency counter = MEM_LAT and owner flag recorded.
- READ_WAIT: counter decrements each edge; at edge ending cycle T+MEM_LAT, mem_rdata captured into owner's rdata register and owner's rvalid set for cycle T+MEM_LAT+1; state returns IDLE on same edge and that edge also arbitrates, so next mem_en may coincide with rvalid (read throughput one per MEM_LAT+1 cycles).
- No requests in IDLE: mem_en low; mem_addr/mem_wdata/mem_we hold last values.
- Requests arriving during READ_WAIT are not granted; requester holds them.
- Request withdrawn before grant: ignored, no grant issued.
- Non-owner rdata register never changes on another requester's return.

## Timing
- Reset (async, rst_n low): state IDLE, starve_cnt 0, latency counter 0, if_gnt/d_gnt/if_rvalid/d_rvalid/mem_en/mem_we 0, mem_addr/mem_wdata/if_rdata/d_rdata 0. Any in-flight read discarded; no rvalid after reset release.
- Request high at edge E (IDLE) → gnt and mem_en high in cycle E+1 (= T).
- Read: rvalid and rdata in T+MEM_LAT+1; with MEM_LAT=1, request-to-data = 3 cycles from first request cycle.
- Store: complete at end of T; no response pulse.
- gnt, rvalid, mem_en never high more than one cycle per transaction; at most one of if_gnt/d_gnt high per cycle.

## Test plan
- Reset: rst_n low asynchronously mid-cycle → all outputs 0 immediately; stay 0 for 3 cycles after release with no requests.
- Single fetch, MEM_LAT=1, memory word 5 = 0x00500093: if_req/if_addr=5 → if_gnt+mem_en(addr 5, we 0) next cycle, if_rvalid with if_rdata=0x00500093 one cycle later; d_rvalid stays 0.
- Simultaneous if_req (addr 2) and d_req load (addr 100): data granted first, fetch granted in cycle of d_rvalid; d_rdata=mem[100], if_rdata=mem[2], returns in order.
- Starvation, STARVE_LIM=4: if_req held, d_req stores held continuously → exactly 4 d_gnt pulses on consecutive cycles, then if_gnt, then data resumes.
- Back-to-back stores addr 10,11,12 with data 0xA,0xB,0xC: mem_en high 3 consecutive cycles with matching mem_addr/mem_wdata, mem_we=1; later loads return 0xA,0xB,0xC.
- Reset mid-read, MEM_LAT=3: rst_n low in T+1 → no if_rvalid ever for that read; after release a new fetch completes normally.
